// File: rtl/bus_mem_responder.sv
// Purpose : bus_if responder with a word-addressed memory, byte-strobed writes, error flagging and completion counters.
// Latency : request sampled in cycle N -> one-cycle ready_o pulse in cycle N+1+WAIT_STATES; one transfer per WAIT_STATES+2 cycles.
// Backpressure: the initiator holds valid_i until ready_o; dropping valid_i while waiting aborts the request with no side effects.
module bus_mem_responder #(
    parameter int          ADDR_W      = 19,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              instr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       write_data_i,
    input  logic [3:0]        wstrb_i,
    output logic [31:0]       read_data_o,
    output logic              ready_o,
    output logic              err_o,
    output logic [31:0]       reads_o,
    output logic [31:0]       writes_o
);

    localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  LP_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]       LP_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_instr;
    logic                r_ready;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [31:0]         r_reads;
    logic [31:0]         r_writes;
    logic [31:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_req_addr;
    logic [3:0]          w_req_wstrb;
    logic                w_req_instr;
    logic                w_oob;
    logic                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_rdata;
    logic                w_go_resp;
    logic                w_mem_we;

    // With zero wait states the response is launched from IDLE, before the
    // request registers are loaded, so the live inputs must be decoded there.
    always_comb begin
        w_req_addr  = (r_state == ST_IDLE) ? addr_i  : r_addr;
        w_req_wstrb = (r_state == ST_IDLE) ? wstrb_i : r_wstrb;
        w_req_instr = (r_state == ST_IDLE) ? instr_i : r_instr;
        w_oob       = ({1'b0, w_req_addr} >= LP_DEPTH);
        w_err       = w_oob | (w_req_instr & (|w_req_wstrb));
        w_idx       = w_req_addr[IDX_W-1:0];
        w_rdata     = w_err ? ERR_DATA : r_mem[w_idx];
        w_go_resp   = valid_i & (((r_state == ST_IDLE) && (WAIT_STATES == 0)) ||
                                 ((r_state == ST_WAIT) && (r_cnt == 4'd0)));
        w_mem_we    = (r_state == ST_RESP) & ~r_err & (|r_wstrb);
    end

    // Request FSM with registered response outputs and completion counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_instr  <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_reads  <= 32'd0;
            r_writes <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            if (w_go_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_err;
                r_rdata <= w_rdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_addr  <= addr_i;
                        r_wdata <= write_data_i;
                        r_wstrb <= wstrb_i;
                        r_instr <= instr_i;
                        r_cnt   <= LP_LOAD;
                        r_state <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (!valid_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    if (!r_err) begin
                        if (r_wstrb == 4'd0) begin
                            r_reads <= r_reads + 32'd1;
                        end else begin
                            r_writes <= r_writes + 32'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane write commit on the edge that ends RESP; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wstrb[k]) begin
                    r_mem[r_addr[IDX_W-1:0]][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign read_data_o = r_rdata;
    assign ready_o     = r_ready;
    assign err_o       = r_err;
    assign reads_o     = r_reads;
    assign writes_o    = r_writes;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (1 and 3 wait states) driven by
// directed scenarios and random traffic, checked against a word-array model.
module tb_bus_mem_responder;

    localparam int AW    = 19;
    localparam int DEPTH = 4096;
    localparam logic [31:0] ERR_W = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [2];
    logic          valid  [2];
    logic          instr  [2];
    logic [AW-1:0] addr   [2];
    logic [31:0]   wdat   [2];
    logic [3:0]    wstrb  [2];
    logic [31:0]   rdata  [2];
    logic          ready  [2];
    logic          err    [2];
    logic [31:0]   reads  [2];
    logic [31:0]   writes [2];

    bus_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(1), .ERR_DATA(ERR_W)) u_ws1 (
        .clk_i(clk), .rst_i(rst[0]), .valid_i(valid[0]), .instr_i(instr[0]), .addr_i(addr[0]),
        .write_data_i(wdat[0]), .wstrb_i(wstrb[0]), .read_data_o(rdata[0]), .ready_o(ready[0]),
        .err_o(err[0]), .reads_o(reads[0]), .writes_o(writes[0]));

    bus_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3), .ERR_DATA(ERR_W)) u_ws3 (
        .clk_i(clk), .rst_i(rst[1]), .valid_i(valid[1]), .instr_i(instr[1]), .addr_i(addr[1]),
        .write_data_i(wdat[1]), .wstrb_i(wstrb[1]), .read_data_o(rdata[1]), .ready_o(ready[1]),
        .err_o(err[1]), .reads_o(reads[1]), .writes_o(writes[1]));

    // Reference model: word array, "word fully known" flags, counters.
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    int unsigned m_reads [2];
    int unsigned m_writes[2];
    int          m_ws    [2] = '{1, 3};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request on instance d; checks latency, outputs and counters.
    task automatic xact(input int d, input logic ins, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] sb, input bit scramble,
                        output logic [31:0] rd_out);
        logic exp_err;
        bit   seen;
        bit   quiet;
        int   lat;
        exp_err = (int'(a) >= DEPTH) || (ins && sb != 4'd0);
        @(negedge clk);
        valid[d] = 1'b1; instr[d] = ins; addr[d] = a; wdat[d] = wd; wstrb[d] = sb;
        seen = 0; quiet = 1; lat = 0; rd_out = 32'd0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (ready[d]) begin
                seen = 1; lat = k; rd_out = rdata[d];
            end else begin
                if (rdata[d] !== 32'd0 || err[d] !== 1'b0) quiet = 0;
                if (scramble) begin
                    addr[d] = AW'($urandom); wdat[d] = $urandom;
                    wstrb[d] = 4'($urandom); instr[d] = 1'($urandom);
                end
            end
        end
        chk("latency", 32'(lat), 32'(m_ws[d] + 1));
        chk("quiet_before_ready", 32'(quiet), 32'd1);
        chk("err", 32'(err[d]), 32'(exp_err));
        if (exp_err)
            chk("err_data", rdata[d], ERR_W);
        else if (sb == 4'd0 && m_known[d][a[11:0]])
            chk("read_data", rdata[d], m_mem[d][a[11:0]]);
        valid[d] = 1'b0; instr[d] = 1'b0; wstrb[d] = 4'd0;
        if (!exp_err) begin
            if (sb == 4'd0) begin
                m_reads[d]++;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (sb[k]) m_mem[d][a[11:0]][8*k +: 8] = wd[8*k +: 8];
                if (sb == 4'hF) m_known[d][a[11:0]] = 1;
                m_writes[d]++;
            end
        end
        @(posedge clk); #1;
        chk("ready_pulse_end", 32'(ready[d]), 32'd0);
        chk("reads", reads[d], m_reads[d]);
        chk("writes", writes[d], m_writes[d]);
    endtask

    logic [31:0] rd;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = '0;
            wdat[d] = 32'd0; wstrb[d] = 4'd0; m_reads[d] = 0; m_writes[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_reads", reads[d], 32'd0);
            chk("rst_writes", writes[d], 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Basic write then read-back on the one-wait-state instance.
        xact(0, 1'b0, AW'(5), 32'h1234_5678, 4'hF, 1'b0, rd);
        xact(0, 1'b0, AW'(5), 32'd0, 4'h0, 1'b0, rd);
        chk("wr_rd_value", rd, 32'h1234_5678);
        chk("wr_rd_reads", reads[0], 32'd1);
        chk("wr_rd_writes", writes[0], 32'd1);

        // Partial byte-lane update.
        xact(0, 1'b0, AW'(9), 32'hAABB_CCDD, 4'hF, 1'b0, rd);
        xact(0, 1'b0, AW'(9), 32'h1122_3344, 4'b0101, 1'b0, rd);
        xact(0, 1'b0, AW'(9), 32'd0, 4'h0, 1'b0, rd);
        chk("strobe_merge", rd, 32'hAA22_CC44);

        // Out-of-range read and the last legal word.
        xact(0, 1'b0, AW'(DEPTH), 32'd0, 4'h0, 1'b0, rd);
        chk("oob_data", rd, 32'hDEAD_BEEF);
        xact(0, 1'b0, AW'(DEPTH - 1), 32'hCAFE_0001, 4'hF, 1'b0, rd);
        xact(0, 1'b0, AW'(DEPTH - 1), 32'd0, 4'h0, 1'b0, rd);

        // Instruction-side write is rejected and leaves memory alone.
        xact(0, 1'b0, AW'(0), 32'h0000_0A0A, 4'hF, 1'b0, rd);
        xact(0, 1'b1, AW'(0), 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
        xact(0, 1'b1, AW'(0), 32'd0, 4'h0, 1'b0, rd);
        chk("instr_write_blocked", rd, 32'h0000_0A0A);

        // Abort during WAIT on the three-wait-state instance.
        xact(1, 1'b0, AW'(7), 32'h0BAD_F00D, 4'hF, 1'b0, rd);
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = AW'(7); wdat[1] = 32'h5555_5555; wstrb[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_no_ready_a", 32'(ready[1]), 32'd0);
        valid[1] = 1'b0; wstrb[1] = 4'd0;
        @(posedge clk); #1;
        chk("abort_no_ready_b", 32'(ready[1]), 32'd0);
        xact(1, 1'b0, AW'(7), 32'd0, 4'h0, 1'b0, rd);
        chk("abort_no_write", rd, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a pending write.
        xact(1, 1'b0, AW'(11), 32'h0F0F_0F0F, 4'hF, 1'b0, rd);
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = AW'(11); wdat[1] = 32'hFFFF_0000; wstrb[1] = 4'hF;
        @(posedge clk); #1;
        #2 rst[1] = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready[1]), 32'd0);
        chk("rst_mid_reads", reads[1], 32'd0);
        chk("rst_mid_writes", writes[1], 32'd0);
        m_reads[1] = 0; m_writes[1] = 0;
        @(negedge clk);
        valid[1] = 1'b0; wstrb[1] = 4'd0;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        xact(1, 1'b0, AW'(11), 32'd0, 4'h0, 1'b0, rd);
        chk("rst_write_lost", rd, 32'h0F0F_0F0F);

        // Random traffic with inputs scrambled after acceptance.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                logic [AW-1:0] ra;
                logic [3:0]    rs;
                logic          ri;
                ra = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, 100))
                                                 : AW'($urandom_range(0, 15));
                rs = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
                ri = ($urandom_range(0, 7) == 0);
                xact(d, ri, ra, $urandom, rs, 1'b1, rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
